// File: rtl/show_pattern.sv
// show_pattern: streams a 5x5 on/off pattern to a chain of WS2812-style
// RGB LEDs as NRZ pulses, then holds the line low to latch, and repeats.
//
// Ports:
//   clk      - system clock (50 MHz nominal)
//   reset_n  - asynchronous active-low reset
//   color    - [2]=red, [1]=green, [0]=blue enable
//   pattern  - pattern[r][c] lights the pixel at row r, column c
//   data     - registered serial LED data line
module show_pattern #(
    parameter int         T_BIT   = 63,
    parameter int         T0H     = 20,
    parameter int         T1H     = 40,
    parameter int         T_LATCH = 2500,
    parameter logic [7:0] BRIGHT  = 8'h20
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      color,
    input  logic [4:0][4:0] pattern,
    output logic            data
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t          r_state;
    logic [4:0][4:0] r_pat;
    logic [2:0]      r_color;
    logic [2:0]      r_row;
    logic [2:0]      r_col;
    logic [4:0]      r_bit;
    logic [11:0]     r_cnt;
    logic            r_data;

    logic            w_on;
    logic [7:0]      w_g;
    logic [7:0]      w_r;
    logic [7:0]      w_b;
    logic [23:0]     w_word;
    logic            w_bit;
    logic [11:0]     w_thr;
    logic            w_last_pix;

    // Current pixel word in GRB order, sent MSB first.
    assign w_on       = r_pat[r_row][r_col];
    assign w_g        = (w_on && r_color[1]) ? BRIGHT : 8'h00;
    assign w_r        = (w_on && r_color[2]) ? BRIGHT : 8'h00;
    assign w_b        = (w_on && r_color[0]) ? BRIGHT : 8'h00;
    assign w_word     = {w_g, w_r, w_b};
    assign w_bit      = w_word[r_bit];
    assign w_thr      = w_bit ? 12'(T1H) : 12'(T0H);
    assign w_last_pix = (r_row == 3'd4) && (r_col == 3'd4);

    assign data = r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_LOAD;
            r_pat   <= '0;
            r_color <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_bit   <= 5'd23;
            r_cnt   <= '0;
            r_data  <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    // Inputs are only sampled here, so a frame is
                    // always self-consistent.
                    r_pat   <= pattern;
                    r_color <= color;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_bit   <= 5'd23;
                    r_cnt   <= '0;
                    r_data  <= 1'b0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    r_data <= (r_cnt < w_thr);
                    if (r_cnt == 12'(T_BIT - 1)) begin
                        r_cnt <= '0;
                        if (r_bit == 5'd0) begin
                            r_bit <= 5'd23;
                            if (w_last_pix) begin
                                r_state <= S_LATCH;
                            end else if (r_col == 3'd4) begin
                                r_col <= '0;
                                r_row <= r_row + 3'd1;
                            end else begin
                                r_col <= r_col + 3'd1;
                            end
                        end else begin
                            r_bit <= r_bit - 5'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end
                S_LATCH: begin
                    r_data <= 1'b0;
                    if (r_cnt == 12'(T_LATCH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end
                default: begin
                    r_data  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_show_pattern.sv
// tb_show_pattern: directed checks of show_pattern pulse widths,
// bit periods, frame latch gap, input resampling and mid-frame reset.
module tb_show_pattern;

    logic            clk;
    logic            reset_n;
    logic [2:0]      color;
    logic [4:0][4:0] pattern;
    logic            data;

    int checks;
    int errors;

    localparam logic [4:0][4:0] P_X =
        {5'b10101, 5'b00100, 5'b00100, 5'b00100, 5'b10101};

    show_pattern dut (
        .clk     (clk),
        .reset_n (reset_n),
        .color   (color),
        .pattern (pattern),
        .data    (data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts on a sample where data is high; returns on the first high
    // sample of the following bit.
    task automatic get_bit(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (data === 1'b1 && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        while (data === 1'b0 && lo < 3000) begin
            lo++;
            @(negedge clk);
        end
    endtask

    task automatic check_pixel(input logic [23:0] word, input string tag);
        int hi, lo;
        for (int i = 23; i >= 0; i--) begin
            get_bit(hi, lo);
            chk($sformatf("%s_b%0d_high", tag, i), hi, word[i] ? 40 : 20);
            chk($sformatf("%s_b%0d_period", tag, i), hi + lo, 63);
        end
    endtask

    task automatic wait_rise(input string tag);
        int n;
        n = 0;
        while (data !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (data === 1'b1 && n <= 2) else begin
            errors++;
            $error("FAIL %s observed=%0d cycles expected<=2", tag, n);
        end
    endtask

    initial begin
        int hi, lo;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        color   = 3'd3;
        pattern = P_X;

        repeat (3) begin
            @(negedge clk);
            chk("reset_data", int'(data), 0);
        end
        reset_n = 1'b1;
        wait_rise("first_rise");

        // Frame 1: colour G+B, pixel 0 on, pixel 1 off.
        check_pixel(24'h200020, "f1_pix0");
        check_pixel(24'h000000, "f1_pix1");

        // Mid-frame change: must not affect the rest of this frame.
        color   = 3'b100;
        pattern = '1;
        check_pixel(24'h200020, "f1_pix2");

        for (int k = 0; k < 22 * 24 - 1; k++) get_bit(hi, lo);
        get_bit(hi, lo);
        chk("f1_last_high", hi, 20);
        // Tail of last bit (43) + latch (2500) + load cycle (1).
        chk("latch_low", lo, 43 + 2500 + 1);

        // Frame 2: red only, all pixels on.
        check_pixel(24'h002000, "f2_pix0");
        check_pixel(24'h002000, "f2_pix1");

        // Reset in the middle of a bit's high phase.
        pattern = P_X;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_data", int'(data), 0);
        repeat (3) begin
            @(negedge clk);
            chk("midreset_hold", int'(data), 0);
        end
        reset_n = 1'b1;
        wait_rise("restart_rise");
        check_pixel(24'h002000, "r_pix0");
        check_pixel(24'h000000, "r_pix1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
